// File: rtl/wb_cmu_arbiter_if.sv
// One Wishbone link (classic pipelined-core CMU flavour).
// "master" is the side that starts cycles; "slave" answers them.
interface wb_cmu_arbiter_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:2] addr;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    modport master (
        output cyc, stb, we, addr, cti, bte, sel, wdata,
        input  rdata, ack, err
    );

    modport slave (
        input  cyc, stb, we, addr, cti, bte, sel, wdata,
        output rdata, ack, err
    );
endinterface

// File: rtl/wb_cmu_arbiter.sv
// Two-master Wishbone arbiter: merges the instruction-side and data-side CMU
// ports onto one shared bus. Round-robin on ties, ownership held for the whole
// CYC, and a per-transfer watchdog that turns a hung slave into ERR.
module wb_cmu_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    wb_cmu_arbiter_if.slave  icmu,
    wb_cmu_arbiter_if.slave  dcmu,
    wb_cmu_arbiter_if.master wb,
    output logic [1:0]       grant_o
);
    // Encoding doubles as the grant_o debug value.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_I = 2'b01,
        OWN_D = 2'b10
    } state_t;

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                last_q, last_d;    // 1: dcmu owned the bus last
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                own_cyc, own_stb;
    logic                stall, tmo;

    // Owner's cyc/stb, taken from the registered state so raw requests never leak
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        case (state_q)
            OWN_I: begin
                own_cyc = icmu.cyc;
                own_stb = icmu.stb;
            end
            OWN_D: begin
                own_cyc = dcmu.cyc;
                own_stb = dcmu.stb;
            end
            default: ;
        endcase
    end

    assign stall = own_cyc & own_stb & ~wb.ack & ~wb.err;
    assign tmo   = (cnt_q == CNT_LAST) & own_stb & ~wb.ack & ~wb.err;

    // Bus and response steering; the non-owner always sees zeros
    always_comb begin
        wb.cyc     = 1'b0;
        wb.stb     = 1'b0;
        wb.we      = 1'b0;
        wb.addr    = '0;
        wb.cti     = '0;
        wb.bte     = '0;
        wb.sel     = '0;
        wb.wdata   = '0;
        icmu.rdata = '0;
        icmu.ack   = 1'b0;
        icmu.err   = 1'b0;
        dcmu.rdata = '0;
        dcmu.ack   = 1'b0;
        dcmu.err   = 1'b0;
        case (state_q)
            OWN_I: begin
                wb.cyc     = icmu.cyc;
                wb.stb     = icmu.stb;
                wb.we      = icmu.we;
                wb.addr    = icmu.addr;
                wb.cti     = icmu.cti;
                wb.bte     = icmu.bte;
                wb.sel     = icmu.sel;
                wb.wdata   = icmu.wdata;
                icmu.rdata = wb.rdata;
                icmu.ack   = wb.ack & icmu.stb;
                icmu.err   = (wb.err | tmo) & icmu.stb;
            end
            OWN_D: begin
                wb.cyc     = dcmu.cyc;
                wb.stb     = dcmu.stb;
                wb.we      = dcmu.we;
                wb.addr    = dcmu.addr;
                wb.cti     = dcmu.cti;
                wb.bte     = dcmu.bte;
                wb.sel     = dcmu.sel;
                wb.wdata   = dcmu.wdata;
                dcmu.rdata = wb.rdata;
                dcmu.ack   = wb.ack & dcmu.stb;
                dcmu.err   = (wb.err | tmo) & dcmu.stb;
            end
            default: ;
        endcase
    end

    // Arbitration and watchdog next-state; a release hands straight to a waiting master
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (icmu.cyc && (!dcmu.cyc || last_q)) begin
                    state_d = OWN_I;
                end else if (dcmu.cyc) begin
                    state_d = OWN_D;
                end
            end
            OWN_I: begin
                if (!icmu.cyc) begin
                    last_d  = 1'b0;
                    state_d = dcmu.cyc ? OWN_D : IDLE;
                end
            end
            OWN_D: begin
                if (!dcmu.cyc) begin
                    last_d  = 1'b1;
                    state_d = icmu.cyc ? OWN_I : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        cnt_d = (stall && !tmo && (state_d == state_q)) ? cnt_q + 1'b1 : '0;
    end

    // State, round-robin memory and watchdog registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_o = state_q;
endmodule

// File: tb/tb_wb_cmu_arbiter.sv
// Bench for wb_cmu_arbiter: directed scenarios with literal expectations plus
// an owner/wait-time model compared against every output on every cycle.
module tb_wb_cmu_arbiter;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] grant;

    always #5 clk = ~clk;

    wb_cmu_arbiter_if ib();
    wb_cmu_arbiter_if db();
    wb_cmu_arbiter_if sb();

    wb_cmu_arbiter #(.TIMEOUT(TIMEOUT), .CNT_BITS(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .icmu    (ib),
        .dcmu    (db),
        .wb      (sb),
        .grant_o (grant)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner codes: 0 nobody, 1 icmu, 2 dcmu; m_last is the code of the last owner
    int m_owner, m_last, stall_since, cyc_no, m_next;

    function automatic int next_owner(int own, int last, logic ic, logic dc);
        if (own == 1 && ic) return 1;           // owner keeps bus while cyc stays up
        if (own == 2 && dc) return 2;
        if (ic && dc) return (last == 1) ? 2 : 1;  // tie: whoever did not go last
        if (ic) return 1;
        if (dc) return 2;
        return 0;
    endfunction

    assign m_next = next_owner(m_owner, m_last, ib.cyc, db.cyc);

    logic [73:0] e_bus;
    logic [33:0] e_i, e_d;
    logic        e_stall, e_tmo;
    logic [1:0]  e_grant;
    int          e_wait;

    always_comb begin
        e_bus = '0;
        if (m_owner == 1)
            e_bus = {ib.cyc, ib.stb, ib.we, ib.addr, ib.cti, ib.bte, ib.sel, ib.wdata};
        else if (m_owner == 2)
            e_bus = {db.cyc, db.stb, db.we, db.addr, db.cti, db.bte, db.sel, db.wdata};
        e_wait  = (stall_since < 0) ? 0 : (cyc_no - stall_since);
        e_stall = e_bus[73] && e_bus[72] && !sb.ack && !sb.err;
        e_tmo   = e_bus[72] && !sb.ack && !sb.err && (e_wait == TIMEOUT - 1);
        e_i = '0;
        e_d = '0;
        if (m_owner == 1) e_i = {sb.ack & ib.stb, (sb.err | e_tmo) & ib.stb, sb.rdata};
        if (m_owner == 2) e_d = {sb.ack & db.stb, (sb.err | e_tmo) & db.stb, sb.rdata};
        e_grant = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_owner     <= 0;
            m_last      <= 2;
            stall_since <= -1;
            cyc_no      <= 0;
        end else begin
            cyc_no  <= cyc_no + 1;
            m_owner <= m_next;
            if (m_owner != 0 && m_next != m_owner) m_last <= m_owner;
            if (e_stall && !e_tmo && m_next == m_owner)
                stall_since <= (stall_since < 0) ? cyc_no : stall_since;
            else
                stall_since <= -1;
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        check("bus", 128'({sb.cyc, sb.stb, sb.we, sb.addr, sb.cti, sb.bte, sb.sel, sb.wdata}), 128'(e_bus));
        check("grant", 128'(grant), 128'(e_grant));
        check("icmu_rsp", 128'({ib.ack, ib.err, ib.rdata}), 128'(e_i));
        check("dcmu_rsp", 128'({db.ack, db.err, db.rdata}), 128'(e_d));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc_start(); @(posedge clk); #1; endtask
    task automatic settle(); #3; endtask

    task automatic idle_i();
        ib.cyc = 0; ib.stb = 0; ib.we = 0; ib.addr = '0; ib.cti = '0;
        ib.bte = '0; ib.sel = '0; ib.wdata = '0;
    endtask
    task automatic idle_d();
        db.cyc = 0; db.stb = 0; db.we = 0; db.addr = '0; db.cti = '0;
        db.bte = '0; db.sel = '0; db.wdata = '0;
    endtask
    task automatic quiet();
        sb.ack = 0; sb.err = 0; sb.rdata = '0;
    endtask
    task automatic req_i(input logic [29:0] a);
        ib.cyc = 1; ib.stb = 1; ib.addr = a; ib.sel = 4'hF;
    endtask
    task automatic req_d(input logic [29:0] a);
        db.cyc = 1; db.stb = 1; db.addr = a; db.sel = 4'hF;
    endtask

    task automatic do_reset();
        cyc_start();
        rst = 0; idle_i(); idle_d(); quiet();
        #1;
        check("rst_grant", 128'(grant), 128'(2'b00));
        check("rst_cyc", 128'(sb.cyc), 128'(1'b0));
        cyc_start();
        rst = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got running, expected done");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        idle_i(); idle_d(); quiet();
        #2;
        check("por_grant", 128'(grant), 128'(2'b00));
        check("por_cyc", 128'(sb.cyc), 128'(1'b0));
        repeat (2) cyc_start();
        rst = 1;

        // icmu-only single read of byte address 0x1000
        cyc_start(); req_i(30'h400); settle();
        cyc_start(); settle();
        check("rd_cyc", 128'(sb.cyc), 128'(1'b1));
        check("rd_addr", 128'(sb.addr), 128'(30'h400));
        check("rd_grant", 128'(grant), 128'(2'b01));
        cyc_start(); sb.ack = 1; sb.rdata = 32'h2408_0005; settle();
        check("rd_ack", 128'(ib.ack), 128'(1'b1));
        check("rd_data", 128'(ib.rdata), 128'(32'h2408_0005));
        check("rd_dack", 128'(db.ack), 128'(1'b0));
        cyc_start(); idle_i(); quiet(); settle();
        cyc_start(); settle();
        check("rd_release", 128'(grant), 128'(2'b00));

        // both request from reset: icmu first, seamless handover, round-robin
        do_reset();
        cyc_start(); req_i(30'h10); req_d(30'h20); settle();
        cyc_start(); sb.ack = 1; settle();
        check("rr_first", 128'(grant), 128'(2'b01));
        check("rr_addr_i", 128'(sb.addr), 128'(30'h10));
        check("rr_ack_i", 128'(ib.ack), 128'(1'b1));
        check("rr_noack_d", 128'(db.ack), 128'(1'b0));
        cyc_start(); quiet(); idle_i(); settle();
        cyc_start(); sb.ack = 1; settle();
        check("rr_nobubble", 128'(grant), 128'(2'b10));
        check("rr_addr_d", 128'(sb.addr), 128'(30'h20));
        check("rr_ack_d", 128'(db.ack), 128'(1'b1));
        cyc_start(); quiet(); idle_d(); settle();
        cyc_start(); req_i(30'h11); req_d(30'h21); settle();
        check("rr_idle", 128'(grant), 128'(2'b00));
        cyc_start(); settle();
        check("rr_tie_i", 128'(grant), 128'(2'b01));
        cyc_start(); idle_i(); settle();
        cyc_start(); db.cyc = 0; db.stb = 0; req_i(30'h12); settle();
        check("rr_to_d", 128'(grant), 128'(2'b10));
        cyc_start(); req_d(30'h22); settle();
        check("rr_reraise", 128'(grant), 128'(2'b01));
        cyc_start(); idle_i(); settle();
        cyc_start(); idle_d(); settle();
        check("rr_back_d", 128'(grant), 128'(2'b10));
        cyc_start(); settle();

        // dcmu 4-beat incrementing burst while icmu keeps requesting
        do_reset();
        cyc_start(); req_d(30'h100); db.we = 1; db.cti = 3'b010; db.wdata = 32'hA0; settle();
        for (int k = 0; k < 4; k++) begin
            cyc_start();
            if (k == 0) req_i(30'h300);
            db.addr  = 30'(32'h100 + k);
            db.cti   = (k == 3) ? 3'b111 : 3'b010;
            db.wdata = 32'hA0 + k;
            sb.ack = 1;
            settle();
            check("bst_grant", 128'(grant), 128'(2'b10));
            check("bst_ack_d", 128'(db.ack), 128'(1'b1));
            check("bst_ack_i", 128'(ib.ack), 128'(1'b0));
            check("bst_addr", 128'(sb.addr), 128'(32'h100 + k));
        end
        cyc_start(); quiet(); idle_d(); settle();
        cyc_start(); settle();
        check("bst_handover", 128'(grant), 128'(2'b01));
        cyc_start(); idle_i(); settle();

        // slave never answers: one ERR pulse in the 8th stalled cycle
        do_reset();
        cyc_start(); req_i(30'h44); settle();
        for (int t = 1; t <= 9; t++) begin
            cyc_start();
            if (t == 9) idle_i();
            settle();
            check("tmo_err", 128'(ib.err), 128'(t == 8));
        end
        cyc_start(); settle();

        // ACK arriving in the expiry cycle wins over the timeout
        do_reset();
        cyc_start(); req_i(30'h48); settle();
        for (int t = 1; t <= 8; t++) begin
            cyc_start();
            if (t == 8) sb.ack = 1;
            settle();
            check("late_err", 128'(ib.err), 128'(1'b0));
        end
        check("late_ack", 128'(ib.ack), 128'(1'b1));
        cyc_start(); quiet(); idle_i(); settle();

        // slave ERR passes to the owner only
        do_reset();
        cyc_start(); req_i(30'h50); req_d(30'h60); settle();
        cyc_start(); sb.err = 1; settle();
        check("serr_i", 128'(ib.err), 128'(1'b1));
        check("serr_d", 128'(db.err), 128'(1'b0));
        check("serr_ack", 128'(ib.ack), 128'(1'b0));
        cyc_start(); quiet(); idle_i(); settle();
        cyc_start(); idle_d(); settle();
        check("serr_next", 128'(grant), 128'(2'b10));

        // asynchronous reset in the middle of a burst
        do_reset();
        cyc_start(); req_d(30'h200); db.cti = 3'b010; settle();
        cyc_start(); sb.ack = 1; settle();
        cyc_start(); db.addr = 30'h201; settle();
        check("mid_grant", 128'(grant), 128'(2'b10));
        cyc_start(); db.addr = 30'h202;
        #1; rst = 0; #1;
        check("arst_cyc", 128'(sb.cyc), 128'(1'b0));
        check("arst_stb", 128'(sb.stb), 128'(1'b0));
        check("arst_addr", 128'(sb.addr), 128'(30'h0));
        check("arst_grant", 128'(grant), 128'(2'b00));
        check("arst_ack", 128'(db.ack), 128'(1'b0));
        cyc_start(); idle_d(); quiet();
        cyc_start(); rst = 1;
        for (int t = 0; t < 3; t++) begin
            cyc_start(); settle();
            check("post_grant", 128'(grant), 128'(2'b00));
            check("post_cyc", 128'(sb.cyc), 128'(1'b0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
